call_scheduler: RTL and testbench



---
 rtl/call_scheduler_pkg.sv | 19 +
 rtl/call_latch.sv | 41 ++++
 rtl/call_scheduler.sv | 134 +++++++++++++
 tb/tb_call_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/call_scheduler_pkg.sv
// Shared definitions for the elevator call scheduler: FSM encoding,
// default parameters and one-hot floor constants.
package call_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_MOVE   = 2'd2,
    ST_DOOR   = 2'd3
  } sched_state_e;

  localparam int DEF_N_FLOORS    = 3;
  localparam int DEF_DOOR_CYCLES = 3;

  localparam logic [2:0] FLOOR1 = 3'b001;
  localparam logic [2:0] FLOOR2 = 3'b010;
  localparam logic [2:0] FLOOR3 = 3'b100;

endpackage

// File: rtl/call_latch.sv
// Per-floor call button edge detector and pending-call register.
// A simultaneous set and clear on one bit resolves by clr_wins_i.
module call_latch #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] req_i,
  input  logic [W-1:0] clr_i,
  input  logic         clr_wins_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] pending_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] pend_q, pend_d;

  // prev_q resets to 0, so a button held through reset release is an edge
  assign rise_o    = req_i & ~prev_q;
  assign pending_o = pend_q;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < W; i++) begin
      if (rise_o[i] && clr_i[i]) pend_d[i] = ~clr_wins_i;
      else if (rise_o[i])        pend_d[i] = 1'b1;
      else if (clr_i[i])         pend_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= req_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/call_scheduler.sv
// Elevator call scheduler: latches calls, picks the next target with a
// SCAN policy, drives the move request and times the door dwell.
module call_scheduler
  import call_scheduler_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_req_i,
  input  logic [N_FLOORS-1:0] cur_floor_i,
  input  logic                arrived_i,
  input  logic                hold_i,
  output logic [N_FLOORS-1:0] call_pending_o,
  output logic [N_FLOORS-1:0] target_o,
  output logic                go_o,
  output logic                dir_up_o,
  output logic                door_open_o
);

  localparam int             CW    = $clog2(DOOR_CYCLES + 1);
  localparam logic [CW-1:0]  DWELL = CW'(DOOR_CYCLES);

  sched_state_e          state_q, state_d;
  logic                  dir_up_q, dir_up_d;
  logic [N_FLOORS-1:0]   target_q, target_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [N_FLOORS-1:0]   pend, rise, clr, sel_fwd, sel_rev;
  logic                  floor_ok, here_pend, door_next;

  // Nearest pending floor strictly above (up=1) or below (up=0) cur.
  function automatic logic [N_FLOORS-1:0] pick_target(
    input logic [N_FLOORS-1:0] p,
    input logic [N_FLOORS-1:0] cur,
    input logic                up
  );
    logic [N_FLOORS-1:0] below, cand, res;
    below = cur - N_FLOORS'(1);
    cand  = up ? (p & ~(below | cur)) : (p & below);
    res   = '0;
    for (int i = 0; i < N_FLOORS; i++)
      if (cand[i] && (!up || res == '0)) begin
        res    = '0;
        res[i] = 1'b1;
      end
    return res;
  endfunction

  call_latch #(.W(N_FLOORS)) u_latch (
    .clk        (clk),
    .rst        (rst),
    .req_i      (call_req_i),
    .clr_i      (clr),
    .clr_wins_i (door_next),
    .rise_o     (rise),
    .pending_o  (pend)
  );

  assign floor_ok  = $onehot(cur_floor_i);
  assign here_pend = |(pend & cur_floor_i);
  assign sel_fwd   = pick_target(pend, cur_floor_i, dir_up_q);
  assign sel_rev   = pick_target(pend, cur_floor_i, ~dir_up_q);
  // While the door is (or is about to be) open here, the floor's call is
  // served: the clear beats any fresh press at that floor.
  assign door_next = (state_d == ST_DOOR);
  assign clr       = door_next ? cur_floor_i : '0;

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (!floor_ok) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (here_pend)  state_d = ST_DOOR;
          else if (|pend) state_d = ST_SELECT;
        end
        ST_SELECT: begin
          if (|sel_fwd) begin
            target_d = sel_fwd;
            state_d  = ST_MOVE;
          end else if (|sel_rev) begin
            target_d = sel_rev;
            dir_up_d = ~dir_up_q;
            state_d  = ST_MOVE;
          end else begin
            // only call left is at this floor; IDLE will open the door
            state_d = ST_IDLE;
          end
        end
        ST_MOVE: begin
          if (arrived_i && (cur_floor_i == target_q || here_pend))
            state_d = ST_DOOR;
        end
        ST_DOOR: begin
          if (|(rise & cur_floor_i)) begin
            cnt_d = DWELL;
          end else if (!hold_i) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_DOOR && state_q != ST_DOOR) cnt_d = DWELL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dir_up_q <= 1'b1;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign call_pending_o = pend;
  assign target_o       = (state_q == ST_MOVE) ? target_q : '0;
  assign go_o           = (state_q == ST_MOVE) && !hold_i && floor_ok;
  assign door_open_o    = (state_q == ST_DOOR);
  assign dir_up_o       = dir_up_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Randomized scoreboard bench for call_scheduler with an integer-level
// reference model and a simple cabin model closing the movement loop.
module tb_call_scheduler;
  import call_scheduler_pkg::*;

  localparam int N      = 3;
  localparam int DC     = 3;
  localparam int CYCLES = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] call_req, cur_floor, call_pending, target;
  logic         arrived, hold, go, dir_up, door_open;

  call_scheduler #(.N_FLOORS(N), .DOOR_CYCLES(DC)) dut (
    .clk            (clk),
    .rst            (rst),
    .call_req_i     (call_req),
    .cur_floor_i    (cur_floor),
    .arrived_i      (arrived),
    .hold_i         (hold),
    .call_pending_o (call_pending),
    .target_o       (target),
    .go_o           (go),
    .dir_up_o       (dir_up),
    .door_open_o    (door_open)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] pend;
    logic [N-1:0] tgt;
    logic         go;
    logic         dir;
    logic         door;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase name, pending set, sweep direction, target
  // floor number and remaining dwell cycles.
  typedef enum {P_IDLE, P_SEL, P_MOVE, P_DOOR} phase_t;
  phase_t m_ph;
  bit     m_pend [N];
  bit     m_prev [N];
  bit     m_up;
  int     m_tgt;
  int     m_left;

  function automatic int floor_of(logic [N-1:0] v);
    int n = 0, idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic int search(int cf, bit up);
    if (up) begin
      for (int f = cf + 1; f < N; f++) if (m_pend[f]) return f;
    end else begin
      for (int f = cf - 1; f >= 0; f--) if (m_pend[f]) return f;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ph = P_IDLE; m_up = 1'b1; m_tgt = 0; m_left = 0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 1'b0; m_prev[i] = 1'b0; end
  endfunction

  function automatic void model_step();
    int     cf, f;
    bit     rise [N];
    bit     any;
    phase_t nxt;
    if (rst) begin model_reset(); return; end
    cf  = floor_of(cur_floor);
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      rise[i]   = call_req[i] && !m_prev[i];
      m_prev[i] = call_req[i];
      any       = any | m_pend[i];
    end
    nxt = m_ph;
    if (cf < 0) begin
      nxt = P_IDLE;
    end else begin
      case (m_ph)
        P_IDLE: begin
          if (m_pend[cf]) begin nxt = P_DOOR; m_left = DC; end
          else if (any)   nxt = P_SEL;
        end
        P_SEL: begin
          f = search(cf, m_up);
          if (f < 0) begin
            f = search(cf, !m_up);
            if (f >= 0) m_up = !m_up;
          end
          if (f >= 0) begin m_tgt = f; nxt = P_MOVE; end
          else nxt = P_IDLE;
        end
        P_MOVE: begin
          if (arrived && (cf == m_tgt || m_pend[cf])) begin
            nxt = P_DOOR; m_left = DC;
          end
        end
        P_DOOR: begin
          if (rise[cf]) m_left = DC;
          else if (!hold) begin
            m_left--;
            if (m_left == 0) nxt = P_IDLE;
          end
        end
        default: nxt = P_IDLE;
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (nxt == P_DOOR && i == cf) m_pend[i] = 1'b0;
      else if (rise[i])             m_pend[i] = 1'b1;
    end
    m_ph = nxt;
  endfunction

  function automatic obs_t exp_now();
    obs_t o;
    o = '0;
    for (int i = 0; i < N; i++) o.pend[i] = m_pend[i];
    if (m_ph == P_MOVE) o.tgt[m_tgt] = 1'b1;
    o.go   = (m_ph == P_MOVE) && !hold && (floor_of(cur_floor) >= 0);
    o.dir  = m_up;
    o.door = (m_ph == P_DOOR);
    return o;
  endfunction

  // Stimulus: buttons, hold, resets and a cabin that follows the model.
  initial begin
    int cab, mv, travel, hold_left, rst_left;
    bit want_rst;
    logic [N-1:0] fl;
    rst = 1'b1; call_req = '0; cur_floor = FLOOR1; arrived = 1'b0; hold = 1'b0;
    cab = 0; mv = 0; travel = 2; hold_left = 0; rst_left = 3; want_rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      if (cyc % 700 == 350) want_rst = 1'b1;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if (want_rst && (m_ph == P_MOVE || m_ph == P_DOOR)) begin
        rst = 1'b1; rst_left = 2; want_rst = 1'b0;
      end
      if (hold_left > 0) hold_left--;
      else if ($urandom_range(0, 39) == 0) hold_left = $urandom_range(1, 6);
      hold = (hold_left > 0);
      for (int i = 0; i < N; i++) begin
        if (call_req[i]) begin
          if ($urandom_range(0, 2) == 0) call_req[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) call_req[i] = 1'b1;
      end
      arrived = 1'b0;
      if (m_ph == P_MOVE && !hold && !rst) begin
        mv++;
        if (mv >= travel) begin
          cab     = cab + ((m_tgt > cab) ? 1 : -1);
          arrived = 1'b1;
          mv      = 0;
          travel  = $urandom_range(1, 3);
        end
      end else if (m_ph != P_MOVE) mv = 0;
      fl = '0;
      fl[cab] = 1'b1;
      if (m_ph == P_IDLE && !rst && $urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 1) == 0) fl = '0;
        else fl[(cab + 1) % N] = 1'b1;
      end
      cur_floor = fl;
      if (rst) model_reset();
      exp_q.push_back(exp_now());
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: compare every cycle's observed outputs against the scoreboard.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {call_pending, target, go, dir_up, door_open};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got pend=%b tgt=%b go=%b dir=%b door=%b required pend=%b tgt=%b go=%b dir=%b door=%b",
                 $time, a.pend, a.tgt, a.go, a.dir, a.door, e.pend, e.tgt, e.go, e.dir, e.door);
      end
    end
  end

endmodule
